// File: rtl/aes_pkg.sv
// Shared AES constants and the key-bank load state encoding.
package aes_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES128_ROUNDS = 10;
    localparam int AES192_ROUNDS = 12;
    localparam int AES256_ROUNDS = 14;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } key_state_e;

endpackage

// File: rtl/round_key_adder_bank.sv
// Round-key storage: one synchronous write port, one combinational read port.
module round_key_bank #(
    parameter int DATA_W   = 128,
    parameter int NUM_KEYS = 11,
    parameter int AW       = $clog2(NUM_KEYS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_wr_ptr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [NUM_KEYS];
    logic              w_wr_in_range;
    logic              w_rd_in_range;

    // Index is one bit wider for the bound check so a power-of-two bank size can't alias to 0.
    assign w_wr_in_range = {1'b0, i_wr_ptr} < (AW+1)'(NUM_KEYS);
    assign w_rd_in_range = {1'b0, i_rd_idx} < (AW+1)'(NUM_KEYS);

    always_ff @(posedge clk) begin
        if (i_we && w_wr_in_range) begin
            r_mem[i_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = w_rd_in_range ? r_mem[i_rd_idx] : '0;

endmodule

// File: rtl/round_key_adder.sv
// AES key-addition stage: loads a round-key bank, XORs accepted blocks with the
// selected key and presents the result through a one-deep valid/ready register.
module round_key_adder
    import aes_pkg::*;
#(
    parameter  int DATA_W     = AES_BLOCK_W,
    parameter  int NUM_ROUNDS = AES128_ROUNDS,
    localparam int RW         = $clog2(NUM_ROUNDS + 1)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              key_load_start,
    input  logic              key_wr_valid,
    input  logic [DATA_W-1:0] key_wr_data,
    output logic              keys_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RW-1:0]     in_round,
    input  logic              in_decrypt,
    input  logic              in_enable,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    localparam logic [RW-1:0] LAST_IDX = RW'(NUM_ROUNDS);

    key_state_e        r_state;
    key_state_e        w_state_nxt;
    logic [RW-1:0]     r_wr_ptr;
    logic              w_we;
    logic              w_last_wr;
    logic              w_accept;
    logic              w_range_err;
    logic [RW-1:0]     w_rd_idx;
    logic [DATA_W-1:0] w_key;
    logic [DATA_W-1:0] w_result;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_err;

    // A load request in the same cycle wins over a key write.
    assign w_we      = (r_state == LOAD) && key_wr_valid && !key_load_start;
    assign w_last_wr = w_we && (r_wr_ptr == LAST_IDX);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (key_load_start) begin
            w_state_nxt = LOAD;
        end else if (w_last_wr) begin
            w_state_nxt = READY;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
        end else if (key_load_start) begin
            r_wr_ptr <= '0;
        end else if (w_we && !w_last_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    round_key_bank #(
        .DATA_W   (DATA_W),
        .NUM_KEYS (NUM_ROUNDS + 1),
        .AW       (RW)
    ) u_bank (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_data (key_wr_data),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_key)
    );

    assign keys_ready = (r_state == READY);
    assign in_ready   = keys_ready && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;

    // Out-of-range rounds pass the block through flagged; the index never wraps.
    assign w_range_err = in_round > LAST_IDX;
    assign w_rd_idx    = in_decrypt ? (LAST_IDX - in_round) : in_round;
    assign w_result    = (w_range_err || !in_enable) ? in_data : (in_data ^ w_key);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_err   <= w_range_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_round_key_adder.sv
// Bench for round_key_adder: directed FIPS-197 checks plus randomized streams
// scored against a queue-based reference model; a second instance covers 14 rounds.
module tb_round_key_adder;

    localparam int NRA = 10;
    localparam int NRB = 14;
    localparam int RWA = $clog2(NRA + 1);
    localparam int RWB = $clog2(NRB + 1);

    localparam logic [127:0] PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT0  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic [127:0] fips [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6 };

    logic clk, n_rst;
    // instance A (10 rounds)
    logic            key_load_start, key_wr_valid, keys_ready;
    logic [127:0]    key_wr_data;
    logic            in_valid, in_ready, in_decrypt, in_enable;
    logic [127:0]    in_data;
    logic [RWA-1:0]  in_round;
    logic            out_valid, out_ready, out_err;
    logic [127:0]    out_data;
    // instance B (14 rounds)
    logic            b_key_load_start, b_key_wr_valid, b_keys_ready;
    logic [127:0]    b_key_wr_data;
    logic            b_in_valid, b_in_ready, b_in_decrypt, b_in_enable;
    logic [127:0]    b_in_data;
    logic [RWB-1:0]  b_in_round;
    logic            b_out_valid, b_out_ready, b_out_err;
    logic [127:0]    b_out_data;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct { logic [127:0] d; logic e; } exp_t;
    exp_t         exp_q[$];
    logic [127:0] keys_a [0:10];
    logic [127:0] keys_b [0:14];

    round_key_adder #(.DATA_W(128), .NUM_ROUNDS(NRA)) dut_a (
        .clk(clk), .n_rst(n_rst), .key_load_start(key_load_start), .key_wr_valid(key_wr_valid),
        .key_wr_data(key_wr_data), .keys_ready(keys_ready), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_round(in_round), .in_decrypt(in_decrypt), .in_enable(in_enable),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err));

    round_key_adder #(.DATA_W(128), .NUM_ROUNDS(NRB)) dut_b (
        .clk(clk), .n_rst(n_rst), .key_load_start(b_key_load_start), .key_wr_valid(b_key_wr_valid),
        .key_wr_data(b_key_wr_data), .keys_ready(b_keys_ready), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_data(b_in_data), .in_round(b_in_round),
        .in_decrypt(b_in_decrypt), .in_enable(b_in_enable), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: key index chosen by direction, out-of-range rounds flagged and passed through.
    function automatic exp_t model(logic [127:0] d, int rnd, bit dec, bit en);
        exp_t r;
        r.d = d;
        r.e = 1'b0;
        if (rnd > NRA)  r.e = 1'b1;
        else if (en)    r.d = d ^ keys_a[dec ? NRA - rnd : rnd];
        return r;
    endfunction

    // Scoreboard on the falling edge: outputs hold under stall, each handshake pops one expectation.
    bit           stalled = 1'b0;
    logic [127:0] hold_d;
    logic         hold_e;
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (out_valid === 1'b1) begin
                if (stalled) begin
                    chk("hold_data", out_data, hold_d);
                    chk("hold_err", out_err, hold_e);
                end
                if (out_ready === 1'b1) begin
                    chk("out_has_expect", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        exp_t x;
                        x = exp_q.pop_front();
                        chk("sb_data", out_data, x.d);
                        chk("sb_err", out_err, x.e);
                    end
                end
            end
            stalled = out_valid && !out_ready;
            hold_d  = out_data;
            hold_e  = out_err;
            if (in_valid && in_ready)
                exp_q.push_back(model(in_data, int'(in_round), in_decrypt, in_enable));
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_block();
        in_data    = rnd128();
        in_round   = RWA'($urandom_range(0, 15));
        in_decrypt = 1'($urandom_range(0, 1));
        in_enable  = ($urandom_range(0, 3) != 0);
    endtask

    task automatic load_a(input bit collide);
        key_load_start = 1'b1;
        key_wr_valid   = collide;
        key_wr_data    = rnd128();
        step();
        key_load_start = 1'b0;
        chk("load_start_clr", keys_ready, 0);
        for (int i = 0; i <= NRA; i++) begin
            key_wr_valid = 1'b1;
            key_wr_data  = keys_a[i];
            if (i == NRA) chk("ready_before_last", keys_ready, 0);
            if (i == 5) chk("in_ready_loading", in_ready, 0);
            step();
        end
        key_wr_valid = 1'b0;
        chk("keys_ready_set", keys_ready, 1);
    endtask

    task automatic send_a(input string tag, input logic [127:0] d, input int r, input bit dec,
                          input bit en, input logic [127:0] ed, input bit ee);
        in_valid = 1'b1; in_data = d; in_round = RWA'(r); in_decrypt = dec; in_enable = en;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_err"}, out_err, ee);
    endtask

    task automatic send_b(input string tag, input logic [127:0] d, input int r, input bit dec,
                          input logic [127:0] ed, input bit ee);
        b_in_valid = 1'b1; b_in_data = d; b_in_round = RWB'(r); b_in_decrypt = dec; b_in_enable = 1'b1;
        step();
        b_in_valid = 1'b0;
        chk({tag, "_valid"}, b_out_valid, 1);
        chk({tag, "_data"}, b_out_data, ed);
        chk({tag, "_err"}, b_out_err, ee);
    endtask

    // mode 0: out_ready high; 1: random backpressure; 2: out_ready low on cycles 1..3
    task automatic stream_a(input string tag, input int n, input int mode);
        int sent = 0;
        int cyc  = 0;
        bit acc;
        rand_block();
        while (sent < n && cyc < 2000) begin
            in_valid  = 1'b1;
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1))
                                                        : !(cyc >= 1 && cyc <= 3);
            @(negedge clk);
            if (mode == 0) chk({tag, "_throughput"}, in_ready, 1);
            if (out_valid && !out_ready) chk({tag, "_bp_in_ready"}, in_ready, 0);
            acc = in_ready;
            step();
            cyc++;
            if (acc) begin
                sent++;
                rand_block();
            end
        end
        chk({tag, "_sent"}, sent, n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [127:0] pend;
        n_rst = 1'b0;
        key_load_start = 0; key_wr_valid = 0; key_wr_data = '0; in_valid = 0; in_data = '0;
        in_round = '0; in_decrypt = 0; in_enable = 0; out_ready = 1;
        b_key_load_start = 0; b_key_wr_valid = 0; b_key_wr_data = '0; b_in_valid = 0;
        b_in_data = '0; b_in_round = '0; b_in_decrypt = 0; b_in_enable = 0; b_out_ready = 1;
        for (int i = 0; i <= NRA; i++) keys_a[i] = fips[i];
        for (int i = 0; i <= NRB; i++) keys_b[i] = (i == 0) ? fips[0] : rnd128();
        #1;
        chk("rst_keys_ready", keys_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        step();
        n_rst = 1'b1;
        step();
        in_valid = 1'b1;
        #1;
        chk("idle_in_ready", in_ready, 0);
        in_valid = 1'b0;

        // FIPS-197 schedule, with a write colliding with the load start
        load_a(1'b1);
        key_wr_valid = 1'b1; key_wr_data = rnd128();
        step(); step();
        key_wr_valid = 1'b0;
        send_a("fips_enc_r0", PT, 0, 0, 1, CT0, 0);
        send_a("fips_dec_r10", PT, 10, 1, 1, CT0, 0);
        send_a("fips_dec_r0", PT, 0, 1, 1, PT ^ K10, 0);
        send_a("round11_err", PT, 11, 0, 1, PT, 1);
        send_a("round15_dec_err", PT, 15, 1, 1, PT, 1);
        send_a("bypass_r3", PT, 3, 0, 0, PT, 0);
        send_a("bypass_r12_err", PT, 12, 0, 0, PT, 1);
        step();
        step();
        chk("fips_drained", exp_q.size(), 0);

        stream_a("full_rate", 30, 0);
        stream_a("stall3", 4, 2);
        stream_a("rand_bp", 40, 1);

        // Reload while a block sits stalled in the output register
        in_valid = 1'b1; in_data = rnd128(); in_round = '0; in_decrypt = 0; in_enable = 1;
        pend = in_data ^ keys_a[0];
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        key_load_start = 1'b1;
        step();
        key_load_start = 1'b0;
        chk("reload_keys_ready", keys_ready, 0);
        chk("reload_pend_valid", out_valid, 1);
        chk("reload_pend_data", out_data, pend);
        for (int i = 0; i <= NRA; i++) keys_a[i] = rnd128();
        for (int i = 0; i <= NRA; i++) begin
            key_wr_valid = 1'b1;
            key_wr_data  = keys_a[i];
            rand_block();
            in_valid  = 1'b1;
            out_ready = (i >= 3);
            @(negedge clk);
            chk("reload_in_ready", in_ready, 0);
            if (i < 3) chk("reload_pend_stable", out_data, pend);
            step();
        end
        key_wr_valid = 1'b0;
        chk("reload_done", keys_ready, 1);
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("reload_drained", exp_q.size(), 0);
        stream_a("new_keys", 20, 1);

        // Asynchronous reset mid-load with a pending output
        in_valid = 1'b1; rand_block(); out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        key_load_start = 1'b1;
        step();
        key_load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            key_wr_valid = 1'b1; key_wr_data = rnd128();
            step();
        end
        chk("pre_rst_valid", out_valid, 1);
        #2 n_rst = 1'b0;
        #1;
        chk("async_rst_keys_ready", keys_ready, 0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_data", out_data, 0);
        exp_q.delete();
        key_wr_valid = 1'b0; out_ready = 1'b1;
        step();
        n_rst = 1'b1;
        step();
        chk("post_rst_idle", keys_ready, 0);
        for (int i = 0; i <= NRA; i++) keys_a[i] = fips[i];
        load_a(1'b0);
        send_a("post_rst_fips", PT, 0, 0, 1, CT0, 0);
        step();

        // 14-round instance: bank of 15 keys
        b_key_load_start = 1'b1;
        step();
        b_key_load_start = 1'b0;
        for (int i = 0; i <= NRB; i++) begin
            b_key_wr_valid = 1'b1;
            b_key_wr_data  = keys_b[i];
            if (i == NRB) chk("b_ready_before_last", b_keys_ready, 0);
            step();
        end
        b_key_wr_valid = 1'b0;
        chk("b_keys_ready", b_keys_ready, 1);
        send_b("b_fips_enc_r0", PT, 0, 0, CT0, 0);
        send_b("b_fips_dec_r14", PT, 14, 1, CT0, 0);
        send_b("b_dec_r0", PT, 0, 1, PT ^ keys_b[14], 0);
        send_b("b_enc_r7", PT, 7, 0, PT ^ keys_b[7], 0);
        send_b("b_round15_err", PT, 15, 0, PT, 1);
        step();
        chk("b_drained", b_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
